regfile_bypass_sb: RTL and testbench
====================================

Name: regfile_bypass_sb

Overview:
- Parametrised integer register file for the single-cycle/pipelined RISC-V core.
- Generalises the 2-read/1-write file:
  - configurable word width, depth and read-port count;
  - optional write-to-read bypass;
  - hardwired-zero register 0;
  - per-register busy scoreboard (reserve at issue, clear at writeback) so a pipelined datapath can detect RAW hazards.
- Sits between decode/issue (read, reserve) and writeback (write).

Parameters:
- WORD_LENGTH, 32, data width in bits.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of registers. Must equal 2**ADDR_WIDTH.
- NUM_READ, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see only stored values.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- rd_addr  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  output  NUM_READ*WORD_LENGTH  packed read data, same packing.
- rd_busy  output  NUM_READ  scoreboard busy flag per read port.
- write_add  input  ADDR_WIDTH  writeback address.
- write_data  input  WORD_LENGTH  writeback data.
- write_enable  input  1  writeback strobe.
- rsv_valid  input  1  reservation request from issue.
- rsv_add  input  ADDR_WIDTH  destination register to reserve.
- rsv_ready  output  1  reservation may be accepted this cycle.
- busy_count  output  ADDR_WIDTH+1  number of registers currently busy.

Behaviour:

Reset (rst low, asynchronous, any time including mid-operation):
- All registers cleared to 0 and all busy bits cleared.
- busy_count = 0.
- rd_data reflects the cleared file combinationally.
- rd_busy = 0 and rsv_ready = 1 while held, whatever the inputs.
- Any write or reservation in the reset cycle is lost.

Storage write (on posedge clk when write_enable = 1):
- Register[write_add] <= write_data.
- Suppressed when ZERO_REG = 1 and write_add = 0.

Reads (combinational, per port k, address a):
- ZERO_REG = 1 and a = 0 -> data 0, busy 0.
- Else if BYPASS = 1, write_enable = 1 and write_add = a -> data = write_data.
- Else -> data = register[a].

Scoreboard:
- busy[NUM_REGS] flag bits.
- rsv_ready = !busy[rsv_add], with two overrides:
  - rsv_ready = 1 when rsv_add = 0 and ZERO_REG = 1 (the reservation is then a no-op);
  - rsv_ready = 1 when the same cycle's writeback clears rsv_add.
- A reservation is accepted when rsv_valid & rsv_ready. On the clock edge it sets busy[rsv_add].
- rsv_valid with rsv_ready = 0 is ignored; issue must stall (no state change).
- A writeback with write_enable = 1 clears busy[write_add] on the edge.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Same cycle, same address, accepted reserve + writeback -> data written and busy ends at 1 (the new producer wins).
- rd_busy[k] = busy[a] & ~(write_enable & write_add == a) when BYPASS = 1, so a forwarded operand is not reported busy.
- When BYPASS = 0, rd_busy[k] = busy[a].
- rd_busy[k] = 0 for register 0 when ZERO_REG = 1.

busy_count:
- Registered.
- Updated each edge by +1 on a set of a previously clear bit and −1 on a clear of a previously set bit.
- Net 0 when both events occur on different addresses that cancel.
- Never wraps: range 0..NUM_REGS.
- Always equals the population count of busy after the edge.

General:
- Multiple read ports may address the same register; each returns identical data and busy.
- X on rd_addr produces no state change.

Test Plan:
1. Reset then read all: assert rst=0 mid-stream after writing x5=0xDEADBEEF -> rd_data ports all 0, rd_busy 0, busy_count 0 immediately, without waiting for a clock edge.
2. Zero register: write_enable=1, write_add=0, write_data=0x1234, rsv_valid=1, rsv_add=0 -> rd_data for addr 0 stays 0, rd_busy 0, busy_count 0, rsv_ready 1.
3. Bypass: write x7=0xA5A5A5A5 with rd_addr port0=7 in the same cycle -> rd_data0=0xA5A5A5A5 before the edge (BYPASS=1). With BYPASS=0 it shows the old value 0 until after the edge.
4. Scoreboard RAW: reserve x3 -> next cycle rd_busy for x3 =1, rsv_ready for x3 =0, busy_count=1. Second rsv on x3 ignored (count stays 1). Writeback x3=0x10 -> rd_busy drops combinationally that cycle, busy_count=0 after the edge.
5. Simultaneous reserve + writeback on x9 (already busy) -> rsv_ready=1, x9 gets the new data, busy[9] remains 1, busy_count unchanged.
6. Parametrisation: NUM_READ=3, WORD_LENGTH=64, fill x1..x31 with index*0x0101010101010101, read three distinct addresses per cycle over all combinations -> every port matches the stored values.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : regfile_bypass_sb
// Purpose  : Parametrised integer register file for a pipelined RISC-V core.
//            Provides NUM_READ combinational read ports, an optional
//            same-cycle write-to-read bypass, a hardwired-zero register 0, and
//            a per-register busy scoreboard. Issue reserves a destination
//            register and writeback clears the reservation, which lets the
//            datapath detect RAW hazards.
// Ports    : clk          - rising-edge clock
//            rst          - asynchronous active-low reset
//            rd_addr      - packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//            rd_data      - packed read data, port k at [k*WORD_LENGTH +: WORD_LENGTH]
//            rd_busy      - per-port scoreboard busy flag
//            write_add    - writeback address
//            write_data   - writeback data
//            write_enable - writeback strobe
//            rsv_valid    - reservation request from issue
//            rsv_add      - destination register to reserve
//            rsv_ready    - reservation can be accepted this cycle
//            busy_count   - number of registers currently busy
// Revision : 1.0 - initial release
// ============================================================================
module regfile_bypass_sb #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_REGS    = 32,
    parameter int NUM_READ    = 2,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ*WORD_LENGTH-1:0] rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic [ADDR_WIDTH-1:0]           write_add,
    input  logic [WORD_LENGTH-1:0]          write_data,
    input  logic                            write_enable,
    input  logic                            rsv_valid,
    input  logic [ADDR_WIDTH-1:0]           rsv_add,
    output logic                            rsv_ready,
    output logic [ADDR_WIDTH:0]             busy_count
);

    localparam int                    CW          = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] c_zero_addr = '0;
    localparam bit                    c_zero_reg  = (ZERO_REG != 0);
    localparam bit                    c_bypass    = (BYPASS != 0);

    logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic [CW-1:0]          busy_count_q;
    logic [CW-1:0]          busy_count_d;

    logic wr_live;      // writeback that actually touches state
    logic rsv_is_zero;  // reservation of the hardwired-zero register
    logic wb_hits_rsv;  // this cycle's writeback frees the register being reserved
    logic rsv_accept;
    logic set_new;      // a clear busy bit becomes set
    logic clr_real;     // a set busy bit ends up clear

    assign wr_live     = write_enable && !(c_zero_reg && (write_add == c_zero_addr));
    assign rsv_is_zero = c_zero_reg && (rsv_add == c_zero_addr);
    assign wb_hits_rsv = write_enable && (write_add == rsv_add);

    // While reset is held busy_q is already clear; the !rst term keeps the
    // output at 1 regardless of any other input.
    assign rsv_ready  = !rst || rsv_is_zero || wb_hits_rsv || !busy_q[rsv_add];
    assign rsv_accept = rsv_valid && rsv_ready && !rsv_is_zero;

    // ------------------------------------------------------------------
    // Scoreboard next state. The clear is applied before the set so that a
    // same-address reserve + writeback leaves the bit set (new producer wins).
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wr_live) begin
            busy_d[write_add] = 1'b0;
        end
        if (rsv_accept) begin
            busy_d[rsv_add] = 1'b1;
        end
        set_new      = rsv_accept && !busy_q[rsv_add];
        clr_real     = wr_live && busy_q[write_add] &&
                       !(rsv_accept && (rsv_add == write_add));
        busy_count_d = busy_count_q + CW'(set_new) - CW'(clr_real);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[write_add] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Forwarding is gated by rst so the ports show the cleared
    // file while reset is held, even if a write is being presented.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_zero;
        logic                  fwd;

        assign addr    = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = c_zero_reg && (addr == c_zero_addr);
        assign fwd     = c_bypass && rst && write_enable && (write_add == addr);

        assign rd_data[k*WORD_LENGTH +: WORD_LENGTH] =
            is_zero ? '0 : (fwd ? write_data : regs_q[addr]);
        // A forwarded operand is available now, so it is not reported busy.
        assign rd_busy[k] = !is_zero && busy_q[addr] && !fwd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_regfile_bypass_sb
// Purpose  : Self-checking bench for regfile_bypass_sb. Two instances share
//            the clock, reset and write/reserve stimulus:
//              A - defaults (32-bit, 2 read ports, bypass on)
//              B - 64-bit, 3 read ports, bypass off
//            Both are compared against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_bypass_sb;

    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2*AW-1:0] rd_addr_a;
    logic [63:0]     rd_data_a;
    logic [1:0]      rd_busy_a;
    logic            rsv_ready_a;
    logic [AW:0]     busy_count_a;
    logic [3*AW-1:0] rd_addr_b;
    logic [191:0]    rd_data_b;
    logic [2:0]      rd_busy_b;
    logic            rsv_ready_b;
    logic [AW:0]     busy_count_b;
    logic [AW-1:0]   write_add;
    logic [63:0]     write_data;
    logic            write_enable;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_add;

    regfile_bypass_sb #(
        .WORD_LENGTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .NUM_READ(2), .BYPASS(1), .ZERO_REG(1)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .write_add(write_add), .write_data(write_data[31:0]),
        .write_enable(write_enable), .rsv_valid(rsv_valid), .rsv_add(rsv_add),
        .rsv_ready(rsv_ready_a), .busy_count(busy_count_a)
    );

    regfile_bypass_sb #(
        .WORD_LENGTH(64), .ADDR_WIDTH(AW), .NUM_REGS(NR),
        .NUM_READ(3), .BYPASS(0), .ZERO_REG(1)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .write_add(write_add), .write_data(write_data),
        .write_enable(write_enable), .rsv_valid(rsv_valid), .rsv_add(rsv_add),
        .rsv_ready(rsv_ready_b), .busy_count(busy_count_b)
    );

    // ---------------- reference model ----------------
    logic [63:0] m_mem  [NR];
    bit          m_busy [NR];
    int          n_tests;
    int          n_fail;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input logic [AW-1:0] a, input bit byp, input bit wide);
        logic [63:0] v;
        if (!rst || a == 0)                            v = 64'h0;
        else if (byp && write_enable && write_add == a) v = write_data;
        else                                           v = m_mem[a];
        if (!wide) v = {32'h0, v[31:0]};
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (!rst || a == 0) return 1'b0;
        if (byp && write_enable && write_add == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit exp_ready();
        if (!rst || rsv_add == 0) return 1'b1;
        if (write_enable && write_add == rsv_add) return 1'b1;
        return !m_busy[rsv_add];
    endfunction

    function automatic int exp_count();
        int c = 0;
        if (!rst) return 0;
        for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_edge();
        bit acc;
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                m_mem[i]  = 64'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            acc = rsv_valid && exp_ready() && rsv_add != 0;
            if (write_enable && write_add != 0) begin
                m_mem[write_add]  = write_data;
                m_busy[write_add] = 1'b0;
            end
            if (acc) m_busy[rsv_add] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("%s A%0d data", tag, k), {32'h0, rd_data_a[k*32 +: 32]},
                      exp_data(rd_addr_a[k*AW +: AW], 1'b1, 1'b0));
            check_val($sformatf("%s A%0d busy", tag, k), 64'(rd_busy_a[k]),
                      64'(exp_busy(rd_addr_a[k*AW +: AW], 1'b1)));
        end
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("%s B%0d data", tag, k), rd_data_b[k*64 +: 64],
                      exp_data(rd_addr_b[k*AW +: AW], 1'b0, 1'b1));
            check_val($sformatf("%s B%0d busy", tag, k), 64'(rd_busy_b[k]),
                      64'(exp_busy(rd_addr_b[k*AW +: AW], 1'b0)));
        end
        check_val({tag, " A rsv_ready"}, 64'(rsv_ready_a), 64'(exp_ready()));
        check_val({tag, " B rsv_ready"}, 64'(rsv_ready_b), 64'(exp_ready()));
        check_val({tag, " A busy_count"}, 64'(busy_count_a), 64'(exp_count()));
        check_val({tag, " B busy_count"}, 64'(busy_count_b), 64'(exp_count()));
    endtask

    // Inputs are driven right after a falling edge; checks settle 1 ns later,
    // then the model advances alongside the rising edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit we, input int wa, input logic [63:0] wd, input bit rv, input int ra);
        write_enable = we;
        write_add    = AW'(wa);
        write_data   = wd;
        rsv_valid    = rv;
        rsv_add      = AW'(ra);
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr_a = {AW'(a1), AW'(a0)};
        rd_addr_b = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < NR; i++) begin
            m_mem[i]  = 64'h0;
            m_busy[i] = 1'b0;
        end
        rst = 1'b0;
        drive(0, 0, 64'h0, 0, 0);
        set_rd(0, 0, 0);
        @(negedge clk);
        cycle("reset");
        rst = 1'b1;

        // ---- 1: asynchronous reset mid-stream ----
        drive(1, 5, 64'hDEADBEEF, 1, 6);
        set_rd(5, 6, 5);
        cycle("t1 write");
        drive(0, 0, 64'h0, 0, 0);
        cycle("t1 read");
        drive(1, 5, 64'h1111_2222, 1, 6);
        rst = 1'b0;
        #1;
        check_val("t1 A data0 in reset", {32'h0, rd_data_a[31:0]}, 64'h0);
        check_val("t1 B data0 in reset", rd_data_b[63:0], 64'h0);
        check_val("t1 A busy in reset", 64'(rd_busy_a), 64'h0);
        check_val("t1 count in reset", 64'(busy_count_a), 64'h0);
        check_val("t1 ready in reset", 64'(rsv_ready_a), 64'h1);
        cycle("t1 reset");
        rst = 1'b1;
        drive(0, 0, 64'h0, 0, 0);
        cycle("t1 after");

        // ---- 2: hardwired zero register ----
        drive(1, 0, 64'h1234, 1, 0);
        set_rd(0, 0, 0);
        #1;
        check_val("t2 A data x0", {32'h0, rd_data_a[31:0]}, 64'h0);
        check_val("t2 ready x0", 64'(rsv_ready_a), 64'h1);
        cycle("t2 zero");
        drive(0, 0, 64'h0, 0, 0);
        #1;
        check_val("t2 count", 64'(busy_count_a), 64'h0);
        check_val("t2 busy x0", 64'(rd_busy_a[0]), 64'h0);
        cycle("t2 after");

        // ---- 3: bypass vs no bypass ----
        drive(1, 7, 64'hA5A5A5A5, 0, 0);
        set_rd(7, 0, 7);
        #1;
        check_val("t3 A bypass data", {32'h0, rd_data_a[31:0]}, 64'hA5A5A5A5);
        check_val("t3 B no-bypass data", rd_data_b[63:0], 64'h0);
        cycle("t3 write");
        drive(0, 0, 64'h0, 0, 0);
        #1;
        check_val("t3 B stored data", rd_data_b[63:0], 64'hA5A5A5A5);
        cycle("t3 after");

        // ---- 4: scoreboard RAW ----
        drive(0, 0, 64'h0, 1, 3);
        set_rd(3, 3, 3);
        cycle("t4 reserve");
        #1;
        check_val("t4 busy x3", 64'(rd_busy_a[0]), 64'h1);
        check_val("t4 ready x3", 64'(rsv_ready_a), 64'h0);
        check_val("t4 count", 64'(busy_count_a), 64'h1);
        cycle("t4 second reserve");
        check_val("t4 count after ignored", 64'(busy_count_a), 64'h1);
        drive(1, 3, 64'h10, 0, 0);
        #1;
        check_val("t4 A busy forwarded", 64'(rd_busy_a[0]), 64'h0);
        check_val("t4 B busy unforwarded", 64'(rd_busy_b[0]), 64'h1);
        cycle("t4 writeback");
        drive(0, 0, 64'h0, 0, 0);
        #1;
        check_val("t4 count cleared", 64'(busy_count_a), 64'h0);
        cycle("t4 after");

        // ---- 5: reserve + writeback on an already-busy register ----
        drive(0, 0, 64'h0, 1, 9);
        set_rd(9, 9, 9);
        cycle("t5 reserve");
        drive(1, 9, 64'h99, 1, 9);
        #1;
        check_val("t5 ready same-cycle wb", 64'(rsv_ready_a), 64'h1);
        cycle("t5 both");
        drive(0, 0, 64'h0, 0, 0);
        #1;
        check_val("t5 count", 64'(busy_count_b), 64'h1);
        check_val("t5 busy x9", 64'(rd_busy_b[0]), 64'h1);
        check_val("t5 data x9", rd_data_b[63:0], 64'h99);
        cycle("t5 after");

        // ---- 6: wide, three ports, every address triple ----
        for (int i = 1; i < NR; i++) begin
            drive(1, i, 64'(i) * 64'h0101010101010101, 0, 0);
            cycle("t6 fill");
        end
        drive(0, 0, 64'h0, 0, 0);
        for (int a = 0; a < NR; a++) begin
            for (int b = a + 1; b < NR; b++) begin
                for (int c = b + 1; c < NR; c++) begin
                    set_rd(a, b, c);
                    #1;
                    check_val("t6 B port0", rd_data_b[63:0],    64'(a) * 64'h0101010101010101);
                    check_val("t6 B port1", rd_data_b[127:64],  64'(b) * 64'h0101010101010101);
                    check_val("t6 B port2", rd_data_b[191:128], 64'(c) * 64'h0101010101010101);
                end
            end
        end
        @(negedge clk);

        // ---- randomized traffic ----
        for (int n = 0; n < 800; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 79) != 0);
            drive(($urandom_range(0, 1) == 1),
                  narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR - 1)),
                  {$urandom(), $urandom()},
                  ($urandom_range(0, 1) == 1),
                  narrow ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR - 1)));
            set_rd(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, NR - 1)));
            cycle("rand");
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
